// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the bus initiator.
// Contents: HTRANS / HSIZE / HBURST / HRESP codes and the initiator FSM
// state encoding. There are no ports; files that need these names import
// the package.
package ahb_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE transfer widths
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // HBURST / HRESP
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Initiator FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;

endpackage

// File: rtl/ahb_align_chk.sv
// Combinational legality check for a command's size and alignment.
// Ports:
//   addr_lo_i  in  2  low two address bits
//   size_i     in  3  HSIZE encoding
//   legal_o    out 1  1 when the size is byte/half/word and the address is
//                     naturally aligned for that size
module ahb_align_chk (
    input  logic [1:0] addr_lo_i,
    input  logic [2:0] size_i,
    output logic       legal_o
);
    import ahb_pkg::*;

    always_comb begin
        case (size_i)
            HSIZE_BYTE: legal_o = 1'b1;
            HSIZE_HALF: legal_o = ~addr_lo_i[0];
            HSIZE_WORD: legal_o = (addr_lo_i == 2'b00);
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator. A valid/ready command becomes one
// NONSEQ SINGLE transfer; the slave's reply comes back as a one-cycle
// registered response pulse.
// Ports:
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (accepted when both high)
//   cmd_write/addr/size/wdata    command contents (wdata already lane-placed)
//   rsp_valid/rsp_rdata/rsp_err  response pulse, read data, error flag
//   HADDR..HWDATA                registered AHB-Lite master outputs
//   HRDATA, HREADY, HRESP        AHB-Lite slave-side inputs (from the mux)
module ahb_lite_master #(
    parameter int         ADDR_W    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);
    import ahb_pkg::*;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                hwrite_q, hwrite_d;
    logic [2:0]          hsize_q, hsize_d;
    logic [31:0]         hwdata_q, hwdata_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                cmd_legal;

    ahb_align_chk u_align_chk (
        .addr_lo_i (cmd_addr[1:0]),
        .size_i    (cmd_size),
        .legal_o   (cmd_legal)
    );

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    if (cmd_legal) begin
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = cmd_addr;
                        hwrite_d = cmd_write;
                        hsize_d  = cmd_size;
                        wdata_d  = cmd_wdata;
                        ready_d  = 1'b0;
                        state_d  = ST_ADDR;
                    end else begin
                        // Rejected locally: answer with an error and never
                        // touch the bus.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : 32'h0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // The first ERROR cycle (HRESP=1, HREADY=0) needs no action
                // because HTRANS already went IDLE after the address phase.
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (!hwrite_q && (HRESP == HRESP_OKAY)) ? HRDATA : 32'h0;
                    // Park write data at zero between transfers.
                    hwdata_d    = 32'h0;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                htrans_d = HTRANS_IDLE;
                ready_d  = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_BYTE;
            hwdata_q    <= 32'h0;
            wdata_q     <= 32'h0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: the bench plays both requester and slave,
// so it knows every transfer's wait-state schedule in advance and derives
// the expected bus/response picture for each cycle from that schedule.
module tb_ahb_lite_master;
    import ahb_pkg::*;

    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_lite_master #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // expected picture for the current cycle
    logic        chk_en = 1'b0;
    logic [1:0]  exp_htrans = 2'b00;
    logic        exp_ready  = 1'b1;
    logic        exp_rv     = 1'b0;
    logic        m_err      = 1'b0;
    logic [31:0] m_rdata    = 32'h0;
    logic [31:0] m_haddr    = 32'h0;
    logic        m_hwrite   = 1'b0;
    logic [2:0]  m_hsize    = 3'h0;
    logic [31:0] m_hwdata   = 32'h0;
    logic        chk_hwdata = 1'b0;

    // observations used by the literal checks
    int          p_cyc = 0;
    int          last_rsp_cyc = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;
    int          rsp_cnt = 0;
    int          nonseq_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (rsp_valid) begin
            last_rsp_cyc <= cyc;
            last_rdata   <= rsp_rdata;
            last_err     <= rsp_err;
            rsp_cnt      <= rsp_cnt + 1;
        end
        if (HTRANS == HTRANS_NONSEQ) nonseq_cnt <= nonseq_cnt + 1;
    end

    // per-cycle compare against the expected picture
    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("htrans", {30'h0, HTRANS}, {30'h0, exp_htrans});
            chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, exp_ready});
            chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rv});
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
            chk("rsp_rdata", rsp_rdata, m_rdata);
            if (exp_htrans == HTRANS_NONSEQ) begin
                chk("haddr", HADDR, m_haddr);
                chk("hwrite", {31'h0, HWRITE}, {31'h0, m_hwrite});
                chk("hsize", {29'h0, HSIZE}, {29'h0, m_hsize});
            end
            if (chk_hwdata) chk("hwdata", HWDATA, m_hwdata);
            chk("hburst", {29'h0, HBURST}, 32'h0);
            chk("hprot", {28'h0, HPROT}, 32'h3);
            chk("hmastlock", {31'h0, HMASTLOCK}, 32'h0);
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic garbage_cmd();
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_size  = 3'($urandom);
        cmd_wdata = $urandom;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        HREADY = 1'b1;
        HRESP = 1'b0;
        step();
        exp_rv = 1'b0;
        exp_ready = 1'b1;
        exp_htrans = HTRANS_IDLE;
        chk_hwdata = 1'b0;
    endtask

    // Present a command in the current (ready) cycle and play the slave.
    // aw/dw: address/data-phase wait states; err: two-cycle ERROR reply.
    // Returns in the response cycle with the expectations for it set.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input int aw, input int dw,
                           input logic err, input logic [31:0] rdata);
        logic legal;
        int   nd;
        legal = (size == 3'd0) || (size == 3'd1 && !addr[0]) ||
                (size == 3'd2 && addr[1:0] == 2'b00);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_wdata = wdata;
        p_cyc = cyc;
        step();
        if (!legal) begin
            exp_rv = 1'b1;
            m_err = 1'b1;
            m_rdata = 32'h0;
            exp_ready = 1'b1;
            exp_htrans = HTRANS_IDLE;
            chk_hwdata = 1'b0;
            cmd_valid = 1'b0;
        end else begin
            m_haddr = addr;
            m_hwrite = wr;
            m_hsize = size;
            for (int i = 0; i <= aw; i++) begin
                exp_htrans = HTRANS_NONSEQ;
                exp_ready = 1'b0;
                exp_rv = 1'b0;
                chk_hwdata = !wr;
                m_hwdata = 32'h0;
                garbage_cmd();
                HREADY = (i == aw);
                HRESP = 1'b0;
                HRDATA = $urandom;
                step();
            end
            nd = dw + (err ? 1 : 0) + 1;
            m_hwdata = wr ? wdata : 32'h0;
            for (int j = 0; j < nd; j++) begin
                exp_htrans = HTRANS_IDLE;
                exp_ready = 1'b0;
                exp_rv = 1'b0;
                chk_hwdata = 1'b1;
                garbage_cmd();
                HREADY = (j == nd - 1);
                HRESP = err && (j >= dw);
                HRDATA = (j == nd - 1) ? rdata : $urandom;
                step();
            end
            exp_rv = 1'b1;
            exp_ready = 1'b1;
            m_err = err;
            m_rdata = (!wr && !err) ? rdata : 32'h0;
            exp_htrans = HTRANS_IDLE;
            chk_hwdata = 1'b0;
            m_hwdata = 32'h0;
            cmd_valid = 1'b0;
            HREADY = 1'b1;
            HRESP = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int r0;
        HRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_size = 3'h0; cmd_wdata = 32'h0;
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        step();
        chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
        chk("rst_hsize", {29'h0, HSIZE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk_hwdata = 1'b1;
        chk_en = 1'b1;
        step();
        HRESET = 1'b0;
        idle();

        // zero-wait write
        run_txn(1'b1, 32'h40000000, 3'd2, 32'h0000FFFF, 0, 0, 1'b0, 32'h0);
        idle();
        chk("wr_latency", 32'(last_rsp_cyc - p_cyc), 32'd3);
        chk("wr_err", {31'h0, last_err}, 32'h0);

        // read with three data-phase waits
        run_txn(1'b0, 32'h40000004, 3'd2, 32'h0, 0, 3, 1'b0, 32'hA5A50001);
        idle();
        chk("rd_dwait_latency", 32'(last_rsp_cyc - p_cyc), 32'd6);
        chk("rd_dwait_rdata", last_rdata, 32'hA5A50001);

        // two address-phase waits
        run_txn(1'b0, 32'h40000008, 3'd2, 32'h0, 2, 0, 1'b0, 32'h12345678);
        idle();
        chk("rd_await_latency", 32'(last_rsp_cyc - p_cyc), 32'd5);

        // slave ERROR on a read
        run_txn(1'b0, 32'h4000000C, 3'd2, 32'h0, 0, 0, 1'b1, 32'hDEADBEEF);
        idle();
        chk("err_latency", 32'(last_rsp_cyc - p_cyc), 32'd4);
        chk("err_flag", {31'h0, last_err}, 32'h1);
        chk("err_rdata", last_rdata, 32'h0);

        // rejected commands: misaligned word, then size 3
        n0 = nonseq_cnt;
        run_txn(1'b0, 32'h40000002, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0);
        idle();
        chk("misalign_latency", 32'(last_rsp_cyc - p_cyc), 32'd1);
        chk("misalign_err", {31'h0, last_err}, 32'h1);
        run_txn(1'b0, 32'h40000000, 3'd3, 32'h0, 0, 0, 1'b0, 32'h0);
        idle();
        chk("size3_latency", 32'(last_rsp_cyc - p_cyc), 32'd1);
        chk("size3_err", {31'h0, last_err}, 32'h1);
        chk("reject_no_nonseq", 32'(nonseq_cnt), 32'(n0));

        // reset pulse during the data phase of a write
        r0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40000010;
        cmd_size = 3'd2; cmd_wdata = 32'hCAFEF00D;
        step();
        m_haddr = 32'h40000010; m_hwrite = 1'b1; m_hsize = 3'd2;
        exp_htrans = HTRANS_NONSEQ; exp_ready = 1'b0; exp_rv = 1'b0; chk_hwdata = 1'b0;
        cmd_valid = 1'b0; HREADY = 1'b1;
        step();
        exp_htrans = HTRANS_IDLE; m_hwdata = 32'hCAFEF00D; chk_hwdata = 1'b1;
        HREADY = 1'b0;
        #2;
        HRESET = 1'b1;
        m_hwdata = 32'h0; exp_ready = 1'b1; m_err = 1'b0; m_rdata = 32'h0;
        #1;
        chk("rstmid_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rstmid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        step();
        HRESET = 1'b0;
        HREADY = 1'b1;
        idle();
        idle();
        chk("rstmid_no_rsp", 32'(rsp_cnt), 32'(r0));
        run_txn(1'b0, 32'h40000014, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0BADF00D);
        idle();
        chk("post_rst_latency", 32'(last_rsp_cyc - p_cyc), 32'd3);
        chk("post_rst_rdata", last_rdata, 32'h0BADF00D);

        // randomized traffic
        for (int k = 0; k < 200; k++) begin
            logic [2:0] sz;
            int r;
            r = $urandom_range(0, 9);
            sz = (r == 9) ? 3'd3 : 3'(r % 3);
            run_txn(1'($urandom), $urandom, sz, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        idle();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
